// File: rtl/video_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// video_pkg: shared constants and types for the raster/INT scheduler.
// Rev 1.0
// ------------------------------------------------------------------
package video_pkg;

  localparam int unsigned H_TOTAL_DEF = 448;
  localparam int unsigned V_TOTAL_DEF = 320;
  localparam int unsigned INT_LEN_DEF = 32;

  localparam logic [1:0] INT_NONE  = 2'd0;
  localparam logic [1:0] INT_FRAME = 2'd1;
  localparam logic [1:0] INT_LINE  = 2'd2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } int_state_e;

endpackage
`default_nettype wire

// File: rtl/video_int_sched_if.sv
`default_nettype none
// ------------------------------------------------------------------
// video_int_sched_if: CPU-side interrupt configuration and INT handshake.
// Rev 1.0
// ------------------------------------------------------------------
interface video_int_sched_if;

  logic [7:0] hint_beg;
  logic [8:0] vint_beg;
  logic       int_en_frame;
  logic       int_en_line;
  logic       int_ack;
  logic       int_n;
  logic [1:0] int_src;
  logic       int_miss;

  modport master (
    output hint_beg, vint_beg, int_en_frame, int_en_line, int_ack,
    input  int_n, int_src, int_miss
  );

  modport slave (
    input  hint_beg, vint_beg, int_en_frame, int_en_line, int_ack,
    output int_n, int_src, int_miss
  );

endinterface
`default_nettype wire

// File: rtl/video_raster_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// video_raster_cnt: horizontal/vertical raster counters and line start.
// Rev 1.0
// ------------------------------------------------------------------
module video_raster_cnt
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
  input  wire logic       clk,
  input  wire logic       res_n,
  input  wire logic       ce,
  output logic      [8:0] hcnt,
  output logic      [8:0] vcnt,
  output logic            line_start_s
);

  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       line_start_s_q, line_start_s_d;

  always_comb begin
    hcnt_d         = hcnt_q;
    vcnt_d         = vcnt_q;
    line_start_s_d = 1'b0;
    if (ce) begin
      if (hcnt_q == 9'(H_TOTAL - 1)) begin
        // The pulse lands on the same edge that loads hcnt=0.
        hcnt_d         = '0;
        line_start_s_d = 1'b1;
        vcnt_d         = (vcnt_q == 9'(V_TOTAL - 1)) ? '0 : vcnt_q + 9'd1;
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      line_start_s_q <= 1'b0;
    end else begin
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      line_start_s_q <= line_start_s_d;
    end
  end

  assign hcnt         = hcnt_q;
  assign vcnt         = vcnt_q;
  assign line_start_s = line_start_s_q;

endmodule
`default_nettype wire

// File: rtl/video_int_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// video_int_sched: raster timing plus frame/line interrupt arbitration onto Z80 INT.
// Rev 1.0
// ------------------------------------------------------------------
module video_int_sched
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned INT_LEN = INT_LEN_DEF
) (
  input  wire logic       clk,
  input  wire logic       res_n,
  input  wire logic       ce,
  video_int_sched_if.slave bus,
  output logic      [8:0] hcnt,
  output logic      [8:0] vcnt,
  output logic            line_start_s,
  output logic            int_start
);

  localparam int TMO_W = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(INT_LEN - 1);

  int_state_e       state_q, state_d;
  logic             int_n_q, int_n_d;
  logic [1:0]       int_src_q, int_src_d;
  logic             int_miss_q, int_miss_d;
  logic             int_start_q, int_start_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_pend_q, frame_pend_d;
  logic             line_pend_q, line_pend_d;

  logic hit_h, frame_ev, line_ev, src_dropped, serve_done;

  video_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .clk          (clk),
    .res_n        (res_n),
    .ce           (ce),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .line_start_s (line_start_s)
  );

  // Out-of-range positions can never equal the counters, so they never fire.
  assign hit_h    = (hcnt == {bus.hint_beg, 1'b0});
  assign frame_ev = ce & hit_h & (vcnt == bus.vint_beg) & bus.int_en_frame;
  assign line_ev  = ce & hit_h & bus.int_en_line;

  always_comb begin
    state_d     = state_q;
    int_n_d     = int_n_q;
    int_src_d   = int_src_q;
    tmo_d       = tmo_q;
    int_miss_d  = 1'b0;
    int_start_d = frame_ev;
    src_dropped = 1'b0;
    serve_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_pend_q && bus.int_en_frame) begin
          state_d   = ASSERT;
          int_n_d   = 1'b0;
          int_src_d = INT_FRAME;
          tmo_d     = '0;
        end else if (line_pend_q && bus.int_en_line) begin
          state_d   = ASSERT;
          int_n_d   = 1'b0;
          int_src_d = INT_LINE;
          tmo_d     = '0;
        end
      end
      ASSERT: begin
        src_dropped = ((int_src_q == INT_FRAME) && !bus.int_en_frame) ||
                      ((int_src_q == INT_LINE)  && !bus.int_en_line);
        if (src_dropped || bus.int_ack || (ce && (tmo_q == TMO_MAX))) begin
          serve_done = !src_dropped;
          int_miss_d = !src_dropped && !bus.int_ack;
          state_d    = IDLE;
          int_n_d    = 1'b1;
          int_src_d  = INT_NONE;
        end else if (ce) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        int_n_d   = 1'b1;
        int_src_d = INT_NONE;
      end
    endcase

    // A fresh event beats the service clear; disabling a source always clears it.
    frame_pend_d = bus.int_en_frame &
                   (frame_ev | (frame_pend_q & !(serve_done && (int_src_q == INT_FRAME))));
    line_pend_d  = bus.int_en_line &
                   (line_ev | (line_pend_q & !(serve_done && (int_src_q == INT_LINE))));
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= IDLE;
      int_n_q      <= 1'b1;
      int_src_q    <= INT_NONE;
      int_miss_q   <= 1'b0;
      int_start_q  <= 1'b0;
      tmo_q        <= '0;
      frame_pend_q <= 1'b0;
      line_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_n_q      <= int_n_d;
      int_src_q    <= int_src_d;
      int_miss_q   <= int_miss_d;
      int_start_q  <= int_start_d;
      tmo_q        <= tmo_d;
      frame_pend_q <= frame_pend_d;
      line_pend_q  <= line_pend_d;
    end
  end

  assign bus.int_n    = int_n_q;
  assign bus.int_src  = int_src_q;
  assign bus.int_miss = int_miss_q;
  assign int_start    = int_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_int_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_video_int_sched: directed + randomized checks against a reference model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_video_int_sched;

  localparam int H  = 448;
  localparam int V  = 320;
  localparam int IL = 32;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       ce = 1'b0;
  logic [8:0] hcnt, vcnt;
  logic       line_start_s, int_start;

  video_int_sched_if bus();

  video_int_sched #(.H_TOTAL(H), .V_TOTAL(V), .INT_LEN(IL)) dut (
    .clk          (clk),
    .res_n        (res_n),
    .ce           (ce),
    .bus          (bus),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .line_start_s (line_start_s),
    .int_start    (int_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raster position is just the ce count since reset;
  // the interrupt side tracks which source is on the wire and for how long.
  longint m_ce;
  bit     m_pend [3];
  int     m_src;
  int     m_age;
  bit     m_ls, m_is, m_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ce = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_pend[2] = 0;
    m_src = 0; m_age = 0;
    m_ls = 0; m_is = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int h, v, cur;
    bit ev_h;
    bit ev [3];
    bit en [3];
    h = int'(m_ce % H);
    v = int'((m_ce / H) % V);
    en[0] = 0; en[1] = bus.int_en_frame; en[2] = bus.int_en_line;
    ev_h  = ce && (h == 2 * int'(bus.hint_beg));
    ev[0] = 0;
    ev[1] = ev_h && (v == int'(bus.vint_beg)) && en[1];
    ev[2] = ev_h && en[2];
    m_is   = ev[1];
    m_ls   = ce && (((m_ce + 1) % H) == 0);
    m_miss = 0;
    cur    = m_src;
    if (cur == 0) begin
      if (m_pend[1] && en[1]) begin m_src = 1; m_age = 0; end
      else if (m_pend[2] && en[2]) begin m_src = 2; m_age = 0; end
    end else if (!en[cur]) begin
      m_src = 0;
    end else if (bus.int_ack) begin
      m_src = 0; m_pend[cur] = 0;
    end else if (ce) begin
      if (m_age == IL - 1) begin m_src = 0; m_pend[cur] = 0; m_miss = 1; end
      else m_age++;
    end
    for (int s = 1; s < 3; s++) m_pend[s] = en[s] && (m_pend[s] || ev[s]);
    if (ce) m_ce++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("hcnt", 32'(hcnt), 32'(m_ce % H));
    check("vcnt", 32'(vcnt), 32'((m_ce / H) % V));
    check("line_start_s", 32'(line_start_s), 32'(m_ls));
    check("int_start", 32'(int_start), 32'(m_is));
    check("int_n", 32'(bus.int_n), 32'(m_src == 0));
    check("int_src", 32'(bus.int_src), 32'(m_src));
    check("int_miss", 32'(bus.int_miss), 32'(m_miss));
  endtask

  task automatic wait_int_n(input logic val, input int max, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      tick();
      if (bus.int_n === val) hit = 1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_cnt, low_cnt, lows, starts, ack_div;
    bit seen, miss_seen;

    bus.hint_beg = 8'd0; bus.vint_beg = 9'd0;
    bus.int_en_frame = 1'b0; bus.int_en_line = 1'b0; bus.int_ack = 1'b0;
    model_reset();

    // Reset state
    #22;
    check("rst_hcnt", 32'(hcnt), 32'd0);
    check("rst_vcnt", 32'(vcnt), 32'd0);
    check("rst_line_start", 32'(line_start_s), 32'd0);
    check("rst_int_start", 32'(int_start), 32'd0);
    check("rst_int_n", 32'(bus.int_n), 32'd1);
    check("rst_int_src", 32'(bus.int_src), 32'd0);
    check("rst_int_miss", 32'(bus.int_miss), 32'd0);

    // Counters over two lines
    @(negedge clk);
    res_n = 1'b1; ce = 1'b1;
    ls_cnt = 0;
    for (int i = 0; i < 2 * H + 5; i++) begin
      tick();
      if (line_start_s === 1'b1) begin
        ls_cnt++;
        check("ls_aligned_hcnt0", 32'(hcnt), 32'd0);
      end
    end
    check("ls_count", 32'(ls_cnt), 32'd2);

    // Frame interrupt and acknowledge
    bus.hint_beg = 8'd10; bus.vint_beg = 9'd5; bus.int_en_frame = 1'b1;
    seen = 0;
    for (int i = 0; i < 5 * H && !seen; i++) begin
      tick();
      if (int_start === 1'b1) seen = 1;
    end
    check("frame_int_start_seen", 32'(seen), 32'd1);
    check("frame_int_start_hcnt", 32'(hcnt), 32'd21);
    check("frame_int_start_vcnt", 32'(vcnt), 32'd5);
    tick();
    check("frame_int_n_low", 32'(bus.int_n), 32'd0);
    check("frame_int_src", 32'(bus.int_src), 32'd1);
    repeat (3) tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("frame_ack_int_n", 32'(bus.int_n), 32'd1);
    check("frame_ack_int_src", 32'(bus.int_src), 32'd0);
    bus.int_en_frame = 1'b0;

    // Line interrupt timeout
    bus.hint_beg = 8'd0; bus.int_en_line = 1'b1;
    wait_int_n(1'b0, H + 10, "line_assert_wait");
    low_cnt = 1; miss_seen = 0;
    while (bus.int_n === 1'b0 && low_cnt < 100) begin
      tick();
      if (bus.int_n === 1'b0) low_cnt++;
      else miss_seen = (bus.int_miss === 1'b1);
    end
    check("timeout_low_cycles", 32'(low_cnt), 32'(IL));
    check("timeout_miss_pulse", 32'(miss_seen), 32'd1);
    tick();
    check("timeout_miss_single", 32'(bus.int_miss), 32'd0);
    wait_int_n(1'b0, H + 10, "line_reassert_wait");
    check("line_reassert_src", 32'(bus.int_src), 32'd2);

    // Drop enable mid-assert
    repeat (5) tick();
    bus.int_en_line = 1'b0;
    tick();
    check("disable_int_n", 32'(bus.int_n), 32'd1);
    check("disable_no_miss", 32'(bus.int_miss), 32'd0);

    // Out-of-range horizontal position
    bus.hint_beg = 8'd230; bus.vint_beg = vcnt;
    bus.int_en_line = 1'b1; bus.int_en_frame = 1'b1;
    lows = 0; starts = 0;
    for (int i = 0; i < H + 20; i++) begin
      tick();
      if (bus.int_n === 1'b0) lows++;
      if (int_start === 1'b1) starts++;
    end
    check("oor_no_int", 32'(lows), 32'd0);
    check("oor_no_start", 32'(starts), 32'd0);
    bus.int_en_frame = 1'b0;

    // Asynchronous reset while INT is low
    bus.hint_beg = 8'd50;
    wait_int_n(1'b0, H + 10, "pre_reset_wait");
    #2;
    res_n = 1'b0;
    #1;
    check("async_rst_int_n", 32'(bus.int_n), 32'd1);
    check("async_rst_hcnt", 32'(hcnt), 32'd0);
    check("async_rst_vcnt", 32'(vcnt), 32'd0);
    check("async_rst_int_src", 32'(bus.int_src), 32'd0);
    model_reset();

    // Simultaneous frame and line events
    bus.vint_beg = 9'd0; bus.hint_beg = 8'd4;
    bus.int_en_frame = 1'b1; bus.int_en_line = 1'b1;
    @(negedge clk);
    res_n = 1'b1;
    wait_int_n(1'b0, 20, "simul_wait");
    check("simul_first_frame", 32'(bus.int_src), 32'd1);
    repeat (2) tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("simul_gap_int_n", 32'(bus.int_n), 32'd1);
    tick();
    check("simul_then_line_n", 32'(bus.int_n), 32'd0);
    check("simul_then_line_src", 32'(bus.int_src), 32'd2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;

    // Randomized phases
    for (int p = 0; p < 20; p++) begin
      bus.hint_beg     = 8'($urandom_range(0, 235));
      bus.vint_beg     = vcnt + 9'($urandom_range(0, 1));
      bus.int_en_frame = ($urandom_range(0, 3) != 0);
      bus.int_en_line  = ($urandom_range(0, 3) != 0);
      ack_div          = ($urandom_range(0, 1) != 0) ? 8 : 120;
      for (int i = 0; i < 400; i++) begin
        ce          = ($urandom_range(0, 3) != 0);
        bus.int_ack = ($urandom_range(0, ack_div - 1) == 0);
        if ($urandom_range(0, 199) == 0) bus.int_en_line = ~bus.int_en_line;
        tick();
      end
    end
    bus.int_ack = 1'b0;
    ce = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
